// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and add/sub operation encodings.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } op_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used as a stage of the add_sub ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/add_sub.sv
// Registered adder/subtractor with carry, zero, overflow and negative flags.
// Subtraction reuses the adder by inverting b and injecting select as carry-in.
module add_sub
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             negative
);

  op_e              op_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH:0]   chain_s;

  assign op_s = op_e'(select);

  // Effective b operand: inverted for subtraction
  always_comb begin
    b_eff_s = b;
    case (op_s)
      ADD:     b_eff_s = b;
      SUB:     b_eff_s = ~b;
      default: b_eff_s = b;
    endcase
  end

  // The +1 of two's-complement subtraction enters as the chain carry-in
  assign chain_s[0] = select;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b_eff_s[i]),
      .cin  (chain_s[i]),
      .s    (sum_s[i]),
      .cout (chain_s[i+1])
    );
  end

  // Output register stage; reset wins over any operation in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= {WIDTH{1'b0}};
      carry    <= 1'b0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      negative <= 1'b0;
    end else begin
      out      <= sum_s;
      carry    <= chain_s[WIDTH];
      zero     <= (sum_s == {WIDTH{1'b0}});
      // Signed overflow: carry into the MSB differs from carry out of it
      overflow <= chain_s[WIDTH] ^ chain_s[WIDTH-1];
      negative <= sum_s[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_add_sub.sv
// Scoreboard bench for add_sub: expectations are queued when an operation is
// issued and popped/compared once the registered result appears.
module tb_add_sub;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         select;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] out;
  logic         carry;
  logic         zero;
  logic         overflow;
  logic         negative;

  logic [W+3:0] exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;

  add_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .select   (select),
    .a        (a),
    .b        (b),
    .out      (out),
    .carry    (carry),
    .zero     (zero),
    .overflow (overflow),
    .negative (negative)
  );

  always #5 clk = ~clk;

  // Reference model, packed as {out, carry, zero, overflow, negative}
  function automatic logic [W+3:0] model(input logic r, input logic s,
                                         input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] res;
    logic         c;
    logic         v;
    if (r) return {{W{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0};
    if (!s) begin
      res = x + y;
      c   = (res < x);
      v   = (x[W-1] == y[W-1]) && (res[W-1] != x[W-1]);
    end else begin
      res = x - y;
      c   = (x >= y);
      v   = (x[W-1] != y[W-1]) && (res[W-1] != x[W-1]);
    end
    return {res, c, (res == {W{1'b0}}), v, res[W-1]};
  endfunction

  // Drive one operation, queue its expectation, and step past the capturing edge
  task automatic issue(input logic r, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    rst    = r;
    select = s;
    a      = x;
    b      = y;
    exp_q.push_back(model(r, s, x, y));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [W+3:0] e;
    issue(1'b1, 1'b0, 32'h1234_5678, 32'h0000_0001);
    e = exp_q.pop_front();
    n_cmp++;
    if ({out, carry, zero, overflow, negative} !== e) begin
      n_err++;
      $display("FAIL reset: got %h expected %h", {out, carry, zero, overflow, negative}, e);
    end
    n_cmp++;
    if ({out, carry, zero, overflow, negative} !== {32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_const: got %h", {out, carry, zero, overflow, negative});
    end
  endtask

  task automatic test_add_max;
    logic [W+3:0] e;
    issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    e = exp_q.pop_front();
    n_cmp++;
    if ({out, carry, zero, overflow, negative} !== e ||
        {out, carry, zero, overflow, negative} !== {32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL add_max: got %h expected %h", {out, carry, zero, overflow, negative}, e);
    end
  endtask

  task automatic test_sub;
    logic [W+3:0] e;
    issue(1'b1 ^ 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    e = exp_q.pop_front();
    n_cmp++;
    if ({out, carry, zero, overflow, negative} !== e ||
        {out, carry, zero, overflow, negative} !== {32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL sub_equal: got %h expected %h", {out, carry, zero, overflow, negative}, e);
    end
    issue(1'b0, 1'b1, 32'h0000_0000, 32'h0000_0001);
    e = exp_q.pop_front();
    n_cmp++;
    if ({out, carry, zero, overflow, negative} !== e ||
        {out, carry, zero, negative} !== {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL sub_borrow: got %h expected %h", {out, carry, zero, overflow, negative}, e);
    end
  endtask

  task automatic test_overflow;
    logic [W+3:0] e;
    issue(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
    e = exp_q.pop_front();
    n_cmp++;
    if ({out, carry, zero, overflow, negative} !== e ||
        {out, overflow, carry} !== {32'h8000_0000, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL ovf_add: got %h expected %h", {out, carry, zero, overflow, negative}, e);
    end
    issue(1'b0, 1'b1, 32'h8000_0000, 32'h0000_0001);
    e = exp_q.pop_front();
    n_cmp++;
    if ({out, carry, zero, overflow, negative} !== e ||
        {out, overflow, carry} !== {32'h7FFF_FFFF, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_sub: got %h expected %h", {out, carry, zero, overflow, negative}, e);
    end
  endtask

  task automatic test_hold;
    logic [W+3:0] e;
    issue(1'b0, 1'b0, 32'h0000_0005, 32'h0000_0003);
    e = exp_q.pop_front();
    a      = 32'hDEAD_BEEF;
    b      = 32'h0BAD_F00D;
    select = 1'b1;
    #3;
    n_cmp++;
    if ({out, carry, zero, overflow, negative} !== e) begin
      n_err++;
      $display("FAIL hold: got %h expected %h", {out, carry, zero, overflow, negative}, e);
    end
  endtask

  task automatic test_back_to_back;
    logic [W+3:0] e;
    issue(1'b0, 1'b0, 32'h0000_0005, 32'h0000_0003);
    e = exp_q.pop_front();
    n_cmp++;
    if ({out, carry, zero, overflow, negative} !== e || out !== 32'h0000_0008) begin
      n_err++;
      $display("FAIL b2b_add: got %h expected %h", {out, carry, zero, overflow, negative}, e);
    end
    issue(1'b0, 1'b1, 32'h0000_0005, 32'h0000_0003);
    e = exp_q.pop_front();
    n_cmp++;
    if ({out, carry, zero, overflow, negative} !== e || {out, carry} !== {32'h0000_0002, 1'b1}) begin
      n_err++;
      $display("FAIL b2b_sub: got %h expected %h", {out, carry, zero, overflow, negative}, e);
    end
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    e = exp_q.pop_front();
    n_cmp++;
    if ({out, carry, zero, overflow, negative} !== e ||
        {out, carry, zero, overflow, negative} !== {32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_rst: got %h expected %h", {out, carry, zero, overflow, negative}, e);
    end
  endtask

  task automatic test_random;
    logic [W+3:0] e;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         r;
    logic         s;
    for (int i = 0; i < 60; i++) begin
      r = ($urandom_range(0, 9) == 0);
      s = $urandom_range(0, 1) == 1;
      x = $urandom();
      y = $urandom();
      case ($urandom_range(0, 5))
        0:       y = x;
        1:       x = 32'h8000_0000;
        2:       y = 32'h7FFF_FFFF;
        default: x = x;
      endcase
      issue(r, s, x, y);
      e = exp_q.pop_front();
      n_cmp++;
      if ({out, carry, zero, overflow, negative} !== e) begin
        n_err++;
        $display("FAIL random[%0d] rst=%0b sel=%0b a=%h b=%h: got %h expected %h",
                 i, r, s, x, y, {out, carry, zero, overflow, negative}, e);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    select = 1'b0;
    a      = 32'h0000_0000;
    b      = 32'h0000_0000;
    test_reset();
    test_add_max();
    test_sub();
    test_overflow();
    test_hold();
    test_back_to_back();
    test_random();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
